ysyx_22040759_axi_bridge: RTL and testbench
===========================================

Name: ysyx_22040759_axi_bridge

Overview:
- Responder end of the core's simple fetch and data request interfaces (if_* and mem_*).
- Converts each accepted request into one single-beat AXI4 transaction on a shared 64-bit master port.
- Returns data and response to the requester with a one-cycle ready pulse.
- Sits between the core top and the SoC crossbar; arbitrates fetch against load/store; one outstanding transaction at a time.

Parameters:
- ADDR_W, 64, address width of the request and AXI address channels
- DATA_W, 64, data width; fixed at 64, lane math assumes 8 byte lanes
- AXI_ID_IF, 4'd0, AXI ID driven for fetch reads
- AXI_ID_MEM, 4'd1, AXI ID driven for data reads and writes

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- if_valid  in  1  fetch request pending; held until if_ready
- if_addr  in  64  fetch byte address
- if_size  in  2  00 byte, 01 half, 10 word, 11 dword
- if_ready  out  1  one-cycle completion pulse
- if_data_read  out  64  LSB-aligned read data; valid with if_ready
- if_resp  out  2  AXI RRESP of the fetch; valid with if_ready
- mem_valid  in  1  data request pending; held until mem_ready
- mem_req  in  1  1 = write, 0 = read
- mem_addr  in  64  data byte address
- mem_size  in  2  encoding as if_size
- mem_data_write  in  64  LSB-aligned store data
- mem_ready  out  1  one-cycle completion pulse
- mem_data_read  out  64  LSB-aligned load data; valid with mem_ready
- mem_resp  out  2  RRESP or BRESP; valid with mem_ready
- axi_ar_valid/ready, axi_ar_addr, axi_ar_id  out/in, 1/1, 64, 4  read address channel
- axi_r_valid, axi_r_ready, axi_r_data, axi_r_resp, axi_r_last  in/out/in/in/in, 1/1/64/2/1  read data channel
- axi_aw_valid/ready, axi_aw_addr, axi_aw_id  out/in, 1/1, 64, 4  write address channel
- axi_w_valid/ready, axi_w_data, axi_w_strb, axi_w_last  out/in, 1/1, 64, 8, 1  write data channel
- axi_b_valid, axi_b_ready, axi_b_resp  in/out/in, 1/1/2  write response channel
- axi_ar_len/aw_len, ar_size/aw_size, ar_burst/aw_burst  out, 8, 3, 2  constant 0, {1'b0,size}, 2'b01 (INCR)

Behaviour:
- Reset values:
  - state IDLE
  - all AXI valid/ready outputs 0
  - if_ready and mem_ready 0
  - data and resp outputs 0
  - latched request registers 0
- States and transitions:
  - IDLE:
    - mem_valid has priority over if_valid.
    - On grant, latch owner, addr, size, req and write data. Go to AR for a read, AW_W for a write.
    - The unselected port keeps waiting.
  - AR: ar_valid=1 with latched addr; on ar_ready go to R.
  - R: r_ready=1; on r_valid capture data and resp, go to RESP. r_last is ignored; len is always 0.
  - AW_W:
    - aw_valid and w_valid both asserted.
    - Each channel drops independently after its own handshake. Order of AW and W acceptance is arbitrary, including same cycle.
    - When both are done, go to B.
  - B: b_ready=1; on b_valid capture b_resp, go to RESP.
  - RESP: pulse the owner's ready for exactly one cycle, then IDLE. Request inputs are not sampled in RESP.
- Latency: minimum 4 cycles from valid sampled in IDLE to ready pulse, with a zero-wait slave.
- Address/data rules:
  - AXI address is the unmodified request address; ar_size/aw_size equal the request size.
  - Write data is shifted left by addr[2:0]*8.
  - w_strb = (size mask: 01,03,0F,FF) << addr[2:0].
  - Read data is shifted right by addr[2:0]*8 and masked to size width, zero-extended; sign-extension is the core's job.
  - Misaligned accesses crossing 8 bytes are not split; the slave's behaviour applies.
- Simultaneous if_valid and mem_valid in IDLE: mem granted; if served after mem's RESP.
- Non-OKAY resp is passed through unchanged; no retry.
- A valid deasserted before ready is a protocol violation; the latched request still completes.
- Reset mid-transaction: all valids drop the next cycle, state IDLE, no ready pulse.

Decomposition:
- Shared define file, ysyx_22040759_define.v, holds:
  - size codes
  - AXI burst/resp constants
  - state encodings
- One natural sub-module: ysyx_22040759_axi_lane, combinational shift/strobe/mask for both directions.

Test Plan:
- Fetch, zero-wait slave: if_valid, if_addr=0x80000004, size 10, slave rdata=0x1111_2222_3333_4444 → ar_addr=0x80000004, ar_size=2. if_ready pulses at cycle 4 with if_data_read=0x11112222, if_resp=0.
- Byte store: mem_req=1, addr=0x80001003, size 00, wdata=0xAB → w_strb=0x08, w_data[31:24]=0xAB. mem_ready one cycle after b_valid.
- Both requests in the same cycle → AR for mem issued first with id 1. Fetch AR issued only after mem_ready; each ready pulses exactly once.
- AW and W acceptance skew: aw_ready at cycle 2, w_ready at cycle 5 → aw_valid low from cycle 3, w_valid held until cycle 5. B phase entered once, and the write is not duplicated.
- Error response: slave returns r_resp=2'b10 on a load → mem_resp=2'b10 with the ready pulse, state back to IDLE.
- Reset asserted in state R → next cycle all AXI valid/ready signals 0, no if_ready/mem_ready pulse. A new request after reset completes normally.

Source files
------------

// File: rtl/ysyx_22040759_axi_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22040759_axi_bridge_pkg
//  Description : Shared size codes, AXI constants, bridge state encoding and
//                lane helper functions for the fetch/data AXI bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22040759_axi_bridge_pkg;

  // Request size codes (log2 of byte count)
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  // AXI constants
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  // Bridge state encoding
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW_W = 3'd3,
    ST_B    = 3'd4,
    ST_RESP = 3'd5
  } state_t;

  // Byte-enable pattern of an LSB-aligned access of the given size
  function automatic logic [7:0] size_strb(input logic [1:0] size);
    case (size)
      SIZE_B:  return 8'h01;
      SIZE_H:  return 8'h03;
      SIZE_W:  return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Bit mask of an LSB-aligned access of the given size
  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  return 64'h0000_0000_0000_00FF;
      SIZE_H:  return 64'h0000_0000_0000_FFFF;
      SIZE_W:  return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22040759_axi_bridge_lane.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22040759_axi_bridge_lane
//  Description : Combinational byte-lane steering between LSB-aligned core
//                data and the 64-bit AXI bus (write shift/strobe, read
//                shift/mask with zero extension).
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040759_axi_bridge_lane
  import ysyx_22040759_axi_bridge_pkg::*;
(
  input  logic [2:0]  offset,
  input  logic [1:0]  size,
  input  logic [63:0] wdata_in,
  output logic [63:0] wdata_out,
  output logic [7:0]  wstrb,
  input  logic [63:0] rdata_in,
  output logic [63:0] rdata_out
);

  logic [5:0] w_shamt;

  // Byte offset expressed as a bit shift amount
  assign w_shamt = {offset, 3'b000};

  // Store path moves data up to its lane; load path brings it back down and
  // zero-extends to the access size
  always_comb begin
    wdata_out = wdata_in << w_shamt;
    wstrb     = size_strb(size) << offset;
    rdata_out = (rdata_in >> w_shamt) & size_mask(size);
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_22040759_axi_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22040759_axi_bridge
//  Description : Accepts the core's fetch (if_*) and data (mem_*) requests,
//                arbitrates them (data first) and issues one single-beat AXI4
//                transaction at a time on a shared 64-bit master port.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040759_axi_bridge
  import ysyx_22040759_axi_bridge_pkg::*;
#(
  parameter int         ADDR_W     = 64,
  parameter int         DATA_W     = 64,
  parameter logic [3:0] AXI_ID_IF  = 4'd0,
  parameter logic [3:0] AXI_ID_MEM = 4'd1
) (
  input  logic              clock,
  input  logic              reset,
  // fetch request port
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [1:0]        if_size,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_data_read,
  output logic [1:0]        if_resp,
  // data request port
  input  logic              mem_valid,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_size,
  input  logic [DATA_W-1:0] mem_data_write,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_data_read,
  output logic [1:0]        mem_resp,
  // AXI read address
  output logic              axi_ar_valid,
  input  logic              axi_ar_ready,
  output logic [ADDR_W-1:0] axi_ar_addr,
  output logic [3:0]        axi_ar_id,
  output logic [7:0]        axi_ar_len,
  output logic [2:0]        axi_ar_size,
  output logic [1:0]        axi_ar_burst,
  // AXI read data
  input  logic              axi_r_valid,
  output logic              axi_r_ready,
  input  logic [DATA_W-1:0] axi_r_data,
  input  logic [1:0]        axi_r_resp,
  input  logic              axi_r_last,
  // AXI write address
  output logic              axi_aw_valid,
  input  logic              axi_aw_ready,
  output logic [ADDR_W-1:0] axi_aw_addr,
  output logic [3:0]        axi_aw_id,
  output logic [7:0]        axi_aw_len,
  output logic [2:0]        axi_aw_size,
  output logic [1:0]        axi_aw_burst,
  // AXI write data
  output logic              axi_w_valid,
  input  logic              axi_w_ready,
  output logic [DATA_W-1:0] axi_w_data,
  output logic [7:0]        axi_w_strb,
  output logic              axi_w_last,
  // AXI write response
  input  logic              axi_b_valid,
  output logic              axi_b_ready,
  input  logic [1:0]        axi_b_resp
);

  state_t              r_state, w_state_n;
  logic                r_owner_mem;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_size;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_resp;
  logic                r_aw_done;
  logic                r_w_done;
  logic [DATA_W-1:0]   w_lane_wdata;
  logic [7:0]          w_lane_wstrb;
  logic [DATA_W-1:0]   w_lane_rdata;
  logic                w_unused;

  // Single-beat transfers only, so the last flag carries no information
  assign w_unused = axi_r_last;

  ysyx_22040759_axi_bridge_lane u_lane (
    .offset    (r_addr[2:0]),
    .size      (r_size),
    .wdata_in  (r_wdata),
    .wdata_out (w_lane_wdata),
    .wstrb     (w_lane_wstrb),
    .rdata_in  (axi_r_data),
    .rdata_out (w_lane_rdata)
  );

  assign axi_ar_addr  = r_addr;
  assign axi_ar_id    = r_owner_mem ? AXI_ID_MEM : AXI_ID_IF;
  assign axi_ar_len   = AXI_LEN_SINGLE;
  assign axi_ar_size  = {1'b0, r_size};
  assign axi_ar_burst = AXI_BURST_INCR;
  assign axi_aw_addr  = r_addr;
  assign axi_aw_id    = AXI_ID_MEM;
  assign axi_aw_len   = AXI_LEN_SINGLE;
  assign axi_aw_size  = {1'b0, r_size};
  assign axi_aw_burst = AXI_BURST_INCR;
  assign axi_w_data   = w_lane_wdata;
  assign axi_w_strb   = w_lane_wstrb;
  assign axi_w_last   = axi_w_valid;

  // Both requesters see the same captured data; each only looks at it with its ready
  assign if_data_read  = r_rdata;
  assign mem_data_read = r_rdata;
  assign if_resp       = r_resp;
  assign mem_resp      = r_resp;

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_n;
  end

  // Next state and channel handshake outputs
  always_comb begin
    w_state_n    = r_state;
    axi_ar_valid = 1'b0;
    axi_r_ready  = 1'b0;
    axi_aw_valid = 1'b0;
    axi_w_valid  = 1'b0;
    axi_b_ready  = 1'b0;
    if_ready     = 1'b0;
    mem_ready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_valid)     w_state_n = mem_req ? ST_AW_W : ST_AR;
        else if (if_valid) w_state_n = ST_AR;
      end
      ST_AR: begin
        axi_ar_valid = 1'b1;
        if (axi_ar_ready) w_state_n = ST_R;
      end
      ST_R: begin
        axi_r_ready = 1'b1;
        if (axi_r_valid) w_state_n = ST_RESP;
      end
      ST_AW_W: begin
        axi_aw_valid = !r_aw_done;
        axi_w_valid  = !r_w_done;
        if ((r_aw_done || axi_aw_ready) && (r_w_done || axi_w_ready)) w_state_n = ST_B;
      end
      ST_B: begin
        axi_b_ready = 1'b1;
        if (axi_b_valid) w_state_n = ST_RESP;
      end
      ST_RESP: begin
        if_ready  = !r_owner_mem;
        mem_ready = r_owner_mem;
        w_state_n = ST_IDLE;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // Request latch, AW/W completion tracking and response capture
  always_ff @(posedge clock) begin
    if (reset) begin
      r_owner_mem <= 1'b0;
      r_addr      <= '0;
      r_size      <= SIZE_B;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_resp      <= AXI_RESP_OKAY;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) begin
        if (mem_valid) begin
          r_owner_mem <= 1'b1;
          r_addr      <= mem_addr;
          r_size      <= mem_size;
          r_wdata     <= mem_data_write;
        end else if (if_valid) begin
          r_owner_mem <= 1'b0;
          r_addr      <= if_addr;
          r_size      <= if_size;
        end
      end
      if (r_state == ST_AW_W && w_state_n != ST_B) begin
        if (axi_aw_valid && axi_aw_ready) r_aw_done <= 1'b1;
        if (axi_w_valid && axi_w_ready)   r_w_done  <= 1'b1;
      end else begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (r_state == ST_R && axi_r_valid) begin
        r_rdata <= w_lane_rdata;
        r_resp  <= axi_r_resp;
      end
      if (r_state == ST_B && axi_b_valid) r_resp <= axi_b_resp;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040759_axi_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_22040759_axi_bridge
//  Description : Directed bench for the fetch/data AXI bridge with a
//                latency-programmable AXI slave and a completion scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040759_axi_bridge;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_valid = 1'b0, if_ready;
  logic [63:0] if_addr = '0, if_data_read;
  logic [1:0]  if_size = '0, if_resp;
  logic        mem_valid = 1'b0, mem_req = 1'b0, mem_ready;
  logic [63:0] mem_addr = '0, mem_data_write = '0, mem_data_read;
  logic [1:0]  mem_size = '0, mem_resp;
  logic        axi_ar_valid, axi_ar_ready = 1'b0;
  logic [63:0] axi_ar_addr;
  logic [3:0]  axi_ar_id;
  logic [7:0]  axi_ar_len;
  logic [2:0]  axi_ar_size;
  logic [1:0]  axi_ar_burst;
  logic        axi_r_valid = 1'b0, axi_r_ready, axi_r_last = 1'b0;
  logic [63:0] axi_r_data = '0;
  logic [1:0]  axi_r_resp = '0;
  logic        axi_aw_valid, axi_aw_ready = 1'b0;
  logic [63:0] axi_aw_addr;
  logic [3:0]  axi_aw_id;
  logic [7:0]  axi_aw_len;
  logic [2:0]  axi_aw_size;
  logic [1:0]  axi_aw_burst;
  logic        axi_w_valid, axi_w_ready = 1'b0, axi_w_last;
  logic [63:0] axi_w_data;
  logic [7:0]  axi_w_strb;
  logic        axi_b_valid = 1'b0, axi_b_ready;
  logic [1:0]  axi_b_resp = '0;

  always #5 clock = ~clock;

  ysyx_22040759_axi_bridge dut (
    .clock(clock), .reset(reset),
    .if_valid(if_valid), .if_addr(if_addr), .if_size(if_size), .if_ready(if_ready),
    .if_data_read(if_data_read), .if_resp(if_resp),
    .mem_valid(mem_valid), .mem_req(mem_req), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_data_write(mem_data_write), .mem_ready(mem_ready), .mem_data_read(mem_data_read),
    .mem_resp(mem_resp),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready), .axi_ar_addr(axi_ar_addr),
    .axi_ar_id(axi_ar_id), .axi_ar_len(axi_ar_len), .axi_ar_size(axi_ar_size),
    .axi_ar_burst(axi_ar_burst),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready), .axi_r_data(axi_r_data),
    .axi_r_resp(axi_r_resp), .axi_r_last(axi_r_last),
    .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready), .axi_aw_addr(axi_aw_addr),
    .axi_aw_id(axi_aw_id), .axi_aw_len(axi_aw_len), .axi_aw_size(axi_aw_size),
    .axi_aw_burst(axi_aw_burst),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready), .axi_w_data(axi_w_data),
    .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
    .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready), .axi_b_resp(axi_b_resp)
  );

  // ---------------- scoreboard and counters ----------------
  typedef struct {
    logic        is_mem;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // ---------------- AXI slave model ----------------
  int          ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;
  logic [63:0] slv_rdata = '0;
  logic [1:0]  slv_rresp = '0, slv_bresp = '0;
  int          cyc = 0;
  int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  bit          r_pend = 0, b_pend = 0, aw_got = 0, w_got = 0;
  int          n_ar = 0, n_aw = 0, n_w = 0, n_b = 0;
  int          n_if_rdy = 0, n_mem_rdy = 0, aw_vcyc = 0, w_vcyc = 0, b_cyc = 0;
  logic [63:0] ar_addr_log[16], aw_addr_log[16], w_data_log[16];
  logic [3:0]  ar_id_log[16], aw_id_log[16];
  logic [2:0]  ar_size_log[16], aw_size_log[16];
  logic [7:0]  w_strb_log[16];

  // Handshake bookkeeping at the active edge
  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    end else begin
      if (axi_r_valid && axi_r_ready) r_pend = 0;
      else if (r_pend) r_cnt++;
      if (axi_ar_valid && axi_ar_ready) begin
        ar_addr_log[n_ar % 16] = axi_ar_addr;
        ar_id_log[n_ar % 16]   = axi_ar_id;
        ar_size_log[n_ar % 16] = axi_ar_size;
        n_ar++; ar_cnt = 0; r_pend = 1; r_cnt = 0;
      end else if (axi_ar_valid) ar_cnt++;
      if (axi_b_valid && axi_b_ready) begin b_pend = 0; n_b++; end
      else if (b_pend) b_cnt++;
      if (axi_aw_valid && axi_aw_ready) begin
        aw_addr_log[n_aw % 16] = axi_aw_addr;
        aw_id_log[n_aw % 16]   = axi_aw_id;
        aw_size_log[n_aw % 16] = axi_aw_size;
        n_aw++; aw_cnt = 0; aw_got = 1;
      end else if (axi_aw_valid) aw_cnt++;
      if (axi_w_valid && axi_w_ready) begin
        w_data_log[n_w % 16] = axi_w_data;
        w_strb_log[n_w % 16] = axi_w_strb;
        n_w++; w_cnt = 0; w_got = 1;
      end else if (axi_w_valid) w_cnt++;
      if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0; end
    end
  end

  // Slave drives its ready/valid for the coming edge; monitor counts pulses
  always @(negedge clock) begin
    axi_ar_ready = axi_ar_valid && (ar_cnt >= ar_lat);
    axi_r_valid  = r_pend && (r_cnt >= r_lat);
    axi_r_data   = axi_r_valid ? slv_rdata : 64'd0;
    axi_r_resp   = axi_r_valid ? slv_rresp : 2'd0;
    axi_r_last   = axi_r_valid;
    axi_aw_ready = axi_aw_valid && (aw_cnt >= aw_lat);
    axi_w_ready  = axi_w_valid && (w_cnt >= w_lat);
    axi_b_valid  = b_pend && (b_cnt >= b_lat);
    axi_b_resp   = axi_b_valid ? slv_bresp : 2'd0;
    if (axi_aw_valid) aw_vcyc++;
    if (axi_w_valid)  w_vcyc++;
    if (if_ready)     n_if_rdy++;
    if (mem_ready)    n_mem_rdy++;
    if (axi_b_valid && axi_b_ready) b_cyc = cyc;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic req_fetch(input logic [63:0] a, input logic [1:0] s,
                           input logic [63:0] ed, input logic [1:0] er);
    exp_t e;
    if_valid = 1'b1; if_addr = a; if_size = s;
    e = '{is_mem: 1'b0, data: ed, resp: er, chk_data: 1'b1};
    sb.push_back(e);
  endtask

  task automatic req_mem(input logic wr, input logic [63:0] a, input logic [1:0] s,
                         input logic [63:0] wd, input logic [63:0] ed, input logic [1:0] er);
    exp_t e;
    mem_valid = 1'b1; mem_req = wr; mem_addr = a; mem_size = s; mem_data_write = wd;
    e = '{is_mem: 1'b1, data: ed, resp: er, chk_data: !wr};
    sb.push_back(e);
  endtask

  // Wait for the next ready pulse, score it, then retire that requester's valid
  task automatic wait_ready(input string tag, output int lat, output int rdy_cyc);
    bit   got;
    bit   was_mem;
    exp_t e;
    got = 0; lat = 0; rdy_cyc = 0; was_mem = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (if_ready || mem_ready) begin
        got = 1; lat = i + 1; rdy_cyc = cyc; was_mem = mem_ready;
        break;
      end
    end
    check({tag, "_ready_seen"}, 64'(got), 64'd1);
    if (got) begin
      check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({tag, "_owner_is_mem"}, 64'(was_mem), 64'(e.is_mem));
        check({tag, "_resp"}, 64'(was_mem ? mem_resp : if_resp), 64'(e.resp));
        if (e.chk_data)
          check({tag, "_data"}, was_mem ? mem_data_read : if_data_read, e.data);
      end
      @(posedge clock); #1;
      if (was_mem) mem_valid = 1'b0;
      else         if_valid  = 1'b0;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat, rc, a0, w0, aw0, b0, avc0, wvc0, ir0, mr0;
    bit seen;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_handshakes",
          64'({axi_ar_valid, axi_r_ready, axi_aw_valid, axi_w_valid, axi_b_ready, if_ready, mem_ready}),
          64'd0);
    check("reset_if_data", if_data_read, 64'd0);
    check("reset_mem_data", mem_data_read, 64'd0);
    check("reset_resps", 64'({if_resp, mem_resp}), 64'd0);

    // Fetch, zero-wait slave
    slv_rdata = 64'h1111_2222_3333_4444; slv_rresp = 2'b00;
    @(posedge clock); #1;
    a0 = n_ar;
    req_fetch(64'h8000_0004, 2'b10, 64'h1111_2222, 2'b00);
    wait_ready("fetch", lat, rc);
    check("fetch_latency", 64'(lat), 64'd4);
    check("fetch_ar_addr", ar_addr_log[a0 % 16], 64'h8000_0004);
    check("fetch_ar_size", 64'(ar_size_log[a0 % 16]), 64'd2);
    check("fetch_ar_id", 64'(ar_id_log[a0 % 16]), 64'd0);
    check("ar_len_burst", 64'({axi_ar_len, axi_ar_burst}), 64'h001);

    // Byte store
    slv_bresp = 2'b00;
    aw0 = n_aw; w0 = n_w;
    req_mem(1'b1, 64'h8000_1003, 2'b00, 64'hAB, 64'd0, 2'b00);
    wait_ready("store_b", lat, rc);
    check("store_w_strb", 64'(w_strb_log[w0 % 16]), 64'h08);
    check("store_w_data", w_data_log[w0 % 16], 64'h0000_0000_AB00_0000);
    check("store_aw_addr", aw_addr_log[aw0 % 16], 64'h8000_1003);
    check("store_aw_id_size", 64'({aw_id_log[aw0 % 16], aw_size_log[aw0 % 16]}), 64'({4'd1, 3'd0}));
    check("store_ready_after_b", 64'(rc), 64'(b_cyc + 1));

    // Simultaneous requests: data side first
    slv_rdata = 64'h0123_4567_89AB_CDEF;
    a0 = n_ar; ir0 = n_if_rdy; mr0 = n_mem_rdy;
    req_mem(1'b0, 64'h8000_2000, 2'b11, 64'd0, 64'h0123_4567_89AB_CDEF, 2'b00);
    req_fetch(64'h8000_0000, 2'b10, 64'h89AB_CDEF, 2'b00);
    wait_ready("both_first", lat, rc);
    wait_ready("both_second", lat, rc);
    repeat (3) @(posedge clock); #1;
    check("both_first_ar_id", 64'(ar_id_log[a0 % 16]), 64'd1);
    check("both_second_ar_id", 64'(ar_id_log[(a0 + 1) % 16]), 64'd0);
    check("both_second_ar_addr", ar_addr_log[(a0 + 1) % 16], 64'h8000_0000);
    check("both_ar_count", 64'(n_ar - a0), 64'd2);
    check("both_if_pulses", 64'(n_if_rdy - ir0), 64'd1);
    check("both_mem_pulses", 64'(n_mem_rdy - mr0), 64'd1);

    // AW accepted early, W late
    aw_lat = 1; w_lat = 4;
    aw0 = n_aw; w0 = n_w; b0 = n_b; avc0 = aw_vcyc; wvc0 = w_vcyc;
    req_mem(1'b1, 64'h8000_3000, 2'b11, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 2'b00);
    wait_ready("skew", lat, rc);
    check("skew_aw_valid_cycles", 64'(aw_vcyc - avc0), 64'd2);
    check("skew_w_valid_cycles", 64'(w_vcyc - wvc0), 64'd5);
    check("skew_aw_count", 64'(n_aw - aw0), 64'd1);
    check("skew_w_count", 64'(n_w - w0), 64'd1);
    check("skew_b_count", 64'(n_b - b0), 64'd1);
    check("skew_w_data", w_data_log[w0 % 16], 64'hDEAD_BEEF_CAFE_F00D);
    check("skew_w_strb", 64'(w_strb_log[w0 % 16]), 64'hFF);
    aw_lat = 0; w_lat = 0;

    // Error response on a halfword load
    slv_rdata = 64'h1111_2222_3333_4444; slv_rresp = 2'b10;
    a0 = n_ar;
    req_mem(1'b0, 64'h8000_4006, 2'b01, 64'd0, 64'h1111, 2'b10);
    wait_ready("err_load", lat, rc);
    check("err_ar_size", 64'(ar_size_log[a0 % 16]), 64'd1);
    slv_rresp = 2'b00;
    @(negedge clock);
    check("err_back_idle", 64'({axi_ar_valid, axi_r_ready, if_ready, mem_ready}), 64'd0);

    // Reset while waiting for read data
    r_lat = 20;
    @(posedge clock); #1;
    a0 = n_ar; ir0 = n_if_rdy; mr0 = n_mem_rdy;
    mem_valid = 1'b1; mem_req = 1'b0; mem_addr = 64'h8000_5000; mem_size = 2'b11;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (n_ar != a0) begin seen = 1; break; end
    end
    check("rst_ar_issued", 64'(seen), 64'd1);
    reset = 1'b1; mem_valid = 1'b0;
    @(negedge clock);
    check("rst_in_r_state", 64'(axi_r_ready), 64'd1);
    @(posedge clock); #1;
    reset = 1'b0; r_lat = 0;
    @(negedge clock);
    check("rst_handshakes_low",
          64'({axi_ar_valid, axi_r_ready, axi_aw_valid, axi_w_valid, axi_b_ready, if_ready, mem_ready}),
          64'd0);
    repeat (3) @(posedge clock); #1;
    check("rst_no_ready_pulse", 64'((n_if_rdy - ir0) + (n_mem_rdy - mr0)), 64'd0);

    // Fresh request after reset
    slv_rdata = 64'hFEDC_BA98_7654_3210;
    req_fetch(64'h8000_0010, 2'b11, 64'hFEDC_BA98_7654_3210, 2'b00);
    wait_ready("post_rst_fetch", lat, rc);
    check("post_rst_latency", 64'(lat), 64'd4);

    repeat (4) @(posedge clock); #1;
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
